fir_coeff_ctrl: RTL and testbench

//  Run-time configurator for the 10-tap FIR (Q3.13 coefficients, 1.0 = 0x2000).

---
 rtl/fir_coeff_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_ctrl.sv
// Coefficient shadow/active bank controller for the 10-tap FIR.
// Host writes land in the shadow bank; a commit copies the whole shadow bank
// into the active bank on one edge. The copy happens either on the next edge
// or on the next SYNC pulse, with a timeout that forces it. FIR_EN is then
// held low while the filter pipeline flushes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no copy pending, FIR_EN follows ENABLE_REQ
// S_ARMED  | copy requested, waiting for SYNC (or timeout, or next edge)
// S_SETTLE | active bank just replaced, FIR_EN forced low until count ends
module fir_coeff_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter bit SYNC_MODE     = 1'b1,
  parameter int ARM_TIMEOUT   = 1024
) (
  input  logic         CLK,
  input  logic         RSTb,
  input  logic         WR_STB,
  input  logic [3:0]   WR_ADDR,
  input  logic [15:0]  WR_DATA,
  input  logic [3:0]   RD_ADDR,
  output logic [15:0]  RD_DATA,
  input  logic         COMMIT,
  input  logic         SYNC,
  input  logic         ENABLE_REQ,
  output logic [159:0] COEFF_ALL,
  output logic         FIR_EN,
  output logic         BUSY,
  output logic         DONE,
  output logic         TIMEOUT,
  output logic         ADDR_ERR
);

  localparam int NTAPS = 10;
  localparam logic [15:0] UNITY = 16'h2000;
  localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] ARM_LOAD    = TW'(ARM_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SETTLE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] arm_cnt;
  logic [SW-1:0] settle_cnt;
  logic          pend;
  logic          go, swap, arm_load, settle_done, wr_valid;
  logic [15:0]   rd_mux;
  logic [15:0]   shadow [NTAPS];
  logic [15:0]   active [NTAPS];

  assign wr_valid = WR_STB && (WR_ADDR <= 4'd9);

  // Next-state decode; the arm timer counts down so expiry is a compare to zero.
  always_comb begin
    state_nxt   = state;
    go          = 1'b0;
    swap        = 1'b0;
    arm_load    = 1'b0;
    settle_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (COMMIT) begin
          state_nxt = S_ARMED;
          arm_load  = 1'b1;
        end
      end
      S_ARMED: begin
        go = !SYNC_MODE || SYNC || (arm_cnt == '0);
        if (go) begin
          swap      = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          settle_done = 1'b1;
          // A commit on the final settle edge is treated like one seen earlier.
          if (pend || COMMIT) begin
            state_nxt = S_ARMED;
            arm_load  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, timers, pending flag and registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state      <= S_IDLE;
      arm_cnt    <= '0;
      settle_cnt <= '0;
      pend       <= 1'b0;
      FIR_EN     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm_load)
        arm_cnt <= ARM_LOAD;
      else if (state == S_ARMED)
        arm_cnt <= arm_cnt - TW'(1);
      if (swap)
        settle_cnt <= SETTLE_LOAD;
      else if ((state == S_SETTLE) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - SW'(1);
      if ((state == S_SETTLE) && !settle_done)
        pend <= pend || COMMIT;
      else
        pend <= 1'b0;
      FIR_EN  <= ENABLE_REQ && (state_nxt != S_SETTLE);
      BUSY    <= (state_nxt != S_IDLE);
      DONE    <= settle_done;
      TIMEOUT <= swap && SYNC_MODE && !SYNC;
    end
  end

  // Shadow and active banks; active copies the pre-write shadow on a swap edge.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= (k == 0) ? UNITY : 16'h0000;
        active[k] <= (k == 0) ? UNITY : 16'h0000;
      end
      ADDR_ERR <= 1'b0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (wr_valid && (WR_ADDR == 4'(k)))
          shadow[k] <= WR_DATA;
        if (swap)
          active[k] <= shadow[k];
      end
      if (WR_STB && (WR_ADDR > 4'd9))
        ADDR_ERR <= 1'b1;
    end
  end

  // Readback select; indices beyond the last tap read as zero.
  always_comb begin
    rd_mux = 16'h0000;
    for (int k = 0; k < NTAPS; k++)
      if (RD_ADDR == 4'(k))
        rd_mux = active[k];
  end

  // Registered readback port.
  always_ff @(posedge CLK) begin
    if (!RSTb)
      RD_DATA <= 16'h0000;
    else
      RD_DATA <= rd_mux;
  end

  for (genvar g = 0; g < NTAPS; g++) begin : g_coeff
    assign COEFF_ALL[16*g +: 16] = active[g];
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: three instances share one stimulus stream
// (immediate mode; SYNC mode with long timeout; SYNC mode with 16-cycle timeout).
// The reference model tracks swaps and settle windows as cycle timestamps.
module tb_fir_coeff_ctrl;

  localparam int SETTLE = 8;
  localparam logic [159:0] DEF = {144'h0, 16'h2000};

  logic        CLK = 1'b0;
  logic        RSTb, WR_STB, COMMIT, SYNC, ENABLE_REQ;
  logic [3:0]  WR_ADDR, RD_ADDR;
  logic [15:0] WR_DATA;

  logic [15:0]  rd_o      [3];
  logic [159:0] coeff_o   [3];
  logic         fir_en_o  [3];
  logic         busy_o    [3];
  logic         done_o    [3];
  logic         timeout_o [3];
  logic         addr_err_o[3];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fir_coeff_ctrl #(
      .SETTLE_CYCLES(SETTLE),
      .SYNC_MODE    (g != 0),
      .ARM_TIMEOUT  ((g == 2) ? 16 : 1024)
    ) u_dut (
      .CLK       (CLK),
      .RSTb      (RSTb),
      .WR_STB    (WR_STB),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .RD_ADDR   (RD_ADDR),
      .RD_DATA   (rd_o[g]),
      .COMMIT    (COMMIT),
      .SYNC      (SYNC),
      .ENABLE_REQ(ENABLE_REQ),
      .COEFF_ALL (coeff_o[g]),
      .FIR_EN    (fir_en_o[g]),
      .BUSY      (busy_o[g]),
      .DONE      (done_o[g]),
      .TIMEOUT   (timeout_o[g]),
      .ADDR_ERR  (addr_err_o[g])
    );
  end

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          m_sm  [3] = '{1'b0, 1'b1, 1'b1};
  int          m_tout[3] = '{1024, 1024, 16};
  logic [15:0] m_shadow[3][10];
  logic [15:0] m_active[3][10];
  int          m_arm [3];   // edge on which the commit was accepted, -1 if none
  int          m_end [3];   // edge on which the settle window closes
  bit          m_settling[3];
  bit          m_pend[3];
  logic [15:0] e_rd[3];
  bit          e_fir_en[3], e_busy[3], e_done[3], e_to[3], e_err[3];

  function automatic logic [159:0] m_coeff(int d);
    logic [159:0] r;
    for (int k = 0; k < 10; k++) r[16*k +: 16] = m_active[d][k];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit go;
    int ra, wa;
    cyc++;
    ra = int'(RD_ADDR);
    wa = int'(WR_ADDR);
    for (int d = 0; d < 3; d++) begin
      if (!RSTb) begin
        for (int k = 0; k < 10; k++) begin
          m_shadow[d][k] = (k == 0) ? 16'h2000 : 16'h0;
          m_active[d][k] = (k == 0) ? 16'h2000 : 16'h0;
        end
        m_arm[d] = -1; m_end[d] = 0; m_settling[d] = 0; m_pend[d] = 0;
        e_rd[d] = 16'h0; e_fir_en[d] = 0; e_busy[d] = 0;
        e_done[d] = 0; e_to[d] = 0; e_err[d] = 0;
      end else begin
        e_rd[d]   = (ra <= 9) ? m_active[d][ra] : 16'h0;
        e_done[d] = 0;
        e_to[d]   = 0;
        if (m_settling[d]) begin
          if (cyc == m_end[d]) begin
            e_done[d] = 1;
            m_settling[d] = 0;
            if (m_pend[d] || COMMIT) m_arm[d] = cyc;
            m_pend[d] = 0;
          end else if (COMMIT) begin
            m_pend[d] = 1;
          end
        end else if (m_arm[d] >= 0) begin
          go = !m_sm[d] || SYNC || (cyc - m_arm[d] == m_tout[d]);
          if (go) begin
            for (int k = 0; k < 10; k++) m_active[d][k] = m_shadow[d][k];
            m_settling[d] = 1;
            m_end[d] = cyc + SETTLE;
            e_to[d] = m_sm[d] && !SYNC;
            m_arm[d] = -1;
          end
        end else if (COMMIT) begin
          m_arm[d] = cyc;
        end
        if (WR_STB) begin
          if (wa <= 9) m_shadow[d][wa] = WR_DATA;
          else e_err[d] = 1;
        end
        e_fir_en[d] = ENABLE_REQ && !m_settling[d];
        e_busy[d]   = m_settling[d] || (m_arm[d] >= 0);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WR_STB = 0; WR_ADDR = 0; WR_DATA = 0; RD_ADDR = 0;
    COMMIT = 0; SYNC = 0; ENABLE_REQ = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTb = 0;
    tick();
    RSTb = 1;
  endtask

  task automatic wr(input int a, input logic [15:0] v);
    WR_STB = 1; WR_ADDR = 4'(a); WR_DATA = v;
    tick();
    WR_STB = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    RSTb = 0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (coeff_o[d] !== DEF) begin
        errors++; $display("FAIL reset_coeff dut%0d got %h exp %h", d, coeff_o[d], DEF);
      end
      checks++;
      if ({fir_en_o[d], busy_o[d], done_o[d], timeout_o[d], addr_err_o[d], rd_o[d]} !== 21'h0) begin
        errors++;
        $display("FAIL reset_flags dut%0d got en%b bs%b dn%b to%b er%b rd%h exp all 0", d,
                 fir_en_o[d], busy_o[d], done_o[d], timeout_o[d], addr_err_o[d], rd_o[d]);
      end
    end
    RSTb = 1;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (fir_en_o[d] !== 1'b1) begin
        errors++; $display("FAIL reset_fir_en dut%0d got %b exp 1", d, fir_en_o[d]);
      end
    end
  endtask

  task automatic test_immediate();
    logic [159:0] exp_c;
    int ra[4] = '{0, 5, 9, 12};
    logic [15:0] exp_rd;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      wr(k, 16'(256 * (k + 1)));
      exp_c[16*k +: 16] = 16'(256 * (k + 1));
    end
    COMMIT = 1;
    tick();
    COMMIT = 0;
    checks++;
    if (coeff_o[0] !== DEF || busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL imm_armed got %h busy %b exp %h busy 1", coeff_o[0], busy_o[0], DEF);
    end
    tick();
    checks++;
    if (coeff_o[0] !== exp_c || fir_en_o[0] !== 1'b0) begin
      errors++; $display("FAIL imm_swap got %h en %b exp %h en 0", coeff_o[0], fir_en_o[0], exp_c);
    end
    for (int i = 2; i <= 8; i++) begin
      tick();
      checks++;
      if (fir_en_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
        errors++; $display("FAIL imm_settle t+%0d en %b done %b exp 0 0", i, fir_en_o[0], done_o[0]);
      end
    end
    tick();
    checks++;
    if (fir_en_o[0] !== 1'b1 || done_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL imm_done en %b done %b busy %b exp 1 1 0", fir_en_o[0], done_o[0], busy_o[0]);
    end
    for (int i = 0; i < 4; i++) begin
      RD_ADDR = 4'(ra[i]);
      exp_rd = (ra[i] <= 9) ? 16'(256 * (ra[i] + 1)) : 16'h0;
      tick();
      checks++;
      if (rd_o[0] !== exp_rd) begin
        errors++; $display("FAIL imm_rd addr %0d got %h exp %h", ra[i], rd_o[0], exp_rd);
      end
    end
  endtask

  task automatic test_sync();
    logic [15:0] v;
    int bad;
    v = 16'($urandom);
    do_reset();
    wr(3, v);
    COMMIT = 1;
    tick();
    COMMIT = 0;
    bad = 0;
    for (int i = 1; i < 50; i++) begin
      tick();
      if (coeff_o[1] !== DEF || busy_o[1] !== 1'b1 || timeout_o[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sync_wait bad_cycles %0d exp 0", bad);
    end
    SYNC = 1;
    tick();
    SYNC = 0;
    checks++;
    if (coeff_o[1][63:48] !== v || coeff_o[1] !== m_coeff(1) || timeout_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL sync_swap got %h to %b exp %h to 0", coeff_o[1], timeout_o[1], m_coeff(1));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (busy_o[1] !== e_busy[1] || done_o[1] !== e_done[1] || timeout_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL sync_settle i%0d busy %b done %b exp %b %b", i, busy_o[1], done_o[1],
                 e_busy[1], e_done[1]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] v;
    int pulses;
    v = 16'($urandom);
    do_reset();
    wr(7, v);
    COMMIT = 1;
    tick();
    COMMIT = 0;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (timeout_o[2] === 1'b1) pulses++;
      checks++;
      if (i < 16 && coeff_o[2] !== DEF) begin
        errors++; $display("FAIL to_early i%0d got %h exp %h", i, coeff_o[2], DEF);
      end else if (i == 16 && (coeff_o[2][127:112] !== v || timeout_o[2] !== 1'b1)) begin
        errors++;
        $display("FAIL to_swap got %h to %b exp %h to 1", coeff_o[2][127:112], timeout_o[2], v);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (timeout_o[2] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL to_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    do_reset();
    wr(3, 16'h0777);
    COMMIT = 1;
    tick();
    COMMIT = 0;
    tick();
    dones = (done_o[0] === 1'b1) ? 1 : 0;
    wr(3, 16'h1234);
    checks++;
    if (coeff_o[0][63:48] !== 16'h0777) begin
      errors++; $display("FAIL b2b_first got %h exp 0777", coeff_o[0][63:48]);
    end
    COMMIT = 1;
    tick();
    COMMIT = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o[0] === 1'b1) dones++;
    end
    checks++;
    if (dones != 2 || coeff_o[0][63:48] !== 16'h1234 || busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second dones %0d c3 %h busy %b exp 2 1234 0", dones, coeff_o[0][63:48],
               busy_o[0]);
    end
  endtask

  task automatic test_addr_err();
    do_reset();
    wr(12, 16'($urandom));
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (addr_err_o[d] !== 1'b1) begin
        errors++; $display("FAIL aerr_set dut%0d got %b exp 1", d, addr_err_o[d]);
      end
    end
    COMMIT = 1;
    tick();
    COMMIT = 0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (coeff_o[0] !== DEF || addr_err_o[0] !== 1'b1 || addr_err_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL aerr_bank got %h err %b exp %h err 1", coeff_o[0], addr_err_o[0], DEF);
    end
    wr(1, 16'hBEEF);
    COMMIT = 1;
    tick();
    COMMIT = 0;
    tick();
    tick();
    checks++;
    if (busy_o[0] !== 1'b1 || coeff_o[0][31:16] !== 16'hBEEF) begin
      errors++; $display("FAIL aerr_presettle busy %b c1 %h exp 1 beef", busy_o[0], coeff_o[0][31:16]);
    end
    RSTb = 0;
    tick();
    RSTb = 1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (coeff_o[d] !== DEF || {busy_o[d], fir_en_o[d], addr_err_o[d], done_o[d]} !== 4'b0) begin
        errors++;
        $display("FAIL aerr_rst dut%0d got %h bs%b en%b er%b dn%b exp defaults", d, coeff_o[d],
                 busy_o[d], fir_en_o[d], addr_err_o[d], done_o[d]);
      end
    end
    COMMIT = 1;
    tick();
    COMMIT = 0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (coeff_o[0] !== DEF) begin
      errors++; $display("FAIL aerr_shadow_rst got %h exp %h", coeff_o[0], DEF);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      RSTb       = ($urandom_range(0, 199) != 0);
      WR_STB     = ($urandom_range(0, 3) == 0);
      WR_ADDR    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      WR_DATA    = 16'($urandom);
      RD_ADDR    = 4'($urandom_range(0, 15));
      COMMIT     = ($urandom_range(0, 19) == 0);
      SYNC       = ($urandom_range(0, 29) == 0);
      ENABLE_REQ = ($urandom_range(0, 9) != 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({coeff_o[d], rd_o[d], fir_en_o[d], busy_o[d], done_o[d], timeout_o[d], addr_err_o[d]} !==
            {m_coeff(d), e_rd[d], e_fir_en[d], e_busy[d], e_done[d], e_to[d], e_err[d]}) begin
          errors++;
          $display("FAIL rand n%0d dut%0d got c%h rd%h %b%b%b%b%b exp c%h rd%h %b%b%b%b%b", n, d,
                   coeff_o[d], rd_o[d], fir_en_o[d], busy_o[d], done_o[d], timeout_o[d],
                   addr_err_o[d], m_coeff(d), e_rd[d], e_fir_en[d], e_busy[d], e_done[d],
                   e_to[d], e_err[d]);
        end
      end
    end
    idle_inputs();
    RSTb = 1;
  endtask

  initial begin
    RSTb = 0;
    idle_inputs();
    test_reset();
    test_immediate();
    test_sync();
    test_timeout();
    test_back_to_back();
    test_addr_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
